// File: rtl/light_control_timed.sv
// Two-road traffic light controller with one cycle-accurate phase timer.
// Optional LIGHT_FLASH_EN adds a `flash` input and a flashing FL state.
module light_control_timed #(
  parameter int TW       = 8,
  parameter int T_HG_MIN = 8,
  parameter int T_CG_MIN = 2,
  parameter int T_CG_MAX = 16,
  parameter int T_Y      = 4,
  parameter int T_AR     = 3
) (
  input  logic       clk,
  input  logic       clear_n,
  input  logic       car_h,
  input  logic       car_c,
`ifdef LIGHT_FLASH_EN
  input  logic       flash,
`endif
  output logic [1:0] hwy,
  output logic [1:0] cntry,
  output logic [2:0] phase
);

  localparam logic [1:0] RED    = 2'd0;
  localparam logic [1:0] YELLOW = 2'd1;
  localparam logic [1:0] GREEN  = 2'd2;
`ifdef LIGHT_FLASH_EN
  localparam logic [1:0] OFF    = 2'd3;
`endif

  localparam logic [TW-1:0] HG_MIN_M1 = TW'(T_HG_MIN - 1);
  localparam logic [TW-1:0] CG_MIN_M1 = TW'(T_CG_MIN - 1);
  localparam logic [TW-1:0] CG_MAX_M1 = TW'(T_CG_MAX - 1);
  localparam logic [TW-1:0] Y_M1      = TW'(T_Y - 1);
  localparam logic [TW-1:0] AR_M1     = TW'(T_AR - 1);
  localparam logic [TW-1:0] TIMER_MAX = {TW{1'b1}};
`ifdef LIGHT_FLASH_EN
  localparam logic [TW-1:0] Y_LEN     = TW'(T_Y);
  localparam logic [TW-1:0] FL_WRAP   = TW'(2 * T_Y - 1);
`endif

  typedef enum logic [2:0] {
    HG  = 3'd0,
    HY  = 3'd1,
    AR1 = 3'd2,
    CG  = 3'd3,
    CY  = 3'd4,
    AR2 = 3'd5
`ifdef LIGHT_FLASH_EN
    ,
    FL  = 3'd6
`endif
  } state_t;

  state_t        state_reg, state_next;
  logic [TW-1:0] timer_reg, timer_next;
  logic          req;

  assign req   = car_c & ~car_h;
  assign phase = state_reg;

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state_reg <= HG;
      timer_reg <= '0;
    end else begin
      state_reg <= state_next;
      timer_reg <= timer_next;
    end
  end

  // Timer restarts on every state change; in FL it wraps once per flash period.
  always_comb begin
    timer_next = timer_reg;
    if (state_next != state_reg)
      timer_next = '0;
`ifdef LIGHT_FLASH_EN
    else if (state_reg == FL && timer_reg == FL_WRAP)
      timer_next = '0;
`endif
    else if (timer_reg != TIMER_MAX)
      timer_next = timer_reg + 1'b1;
  end

  always_comb begin
    state_next = state_reg;
    hwy        = GREEN;
    cntry      = RED;
    case (state_reg)
      HG: begin
        if (req && timer_reg >= HG_MIN_M1) state_next = HY;
      end
      HY: begin
        hwy = YELLOW;
        if (timer_reg == Y_M1) state_next = AR1;
      end
      AR1: begin
        hwy = RED;
        if (timer_reg == AR_M1) state_next = CG;
      end
      CG: begin
        hwy   = RED;
        cntry = GREEN;
        // Max timeout ends country green even with demand still present.
        if (timer_reg >= CG_MIN_M1 && (!req || timer_reg == CG_MAX_M1))
          state_next = CY;
      end
      CY: begin
        hwy   = RED;
        cntry = YELLOW;
        if (timer_reg == Y_M1) state_next = AR2;
      end
      AR2: begin
        hwy = RED;
        if (timer_reg == AR_M1) state_next = HG;
      end
`ifdef LIGHT_FLASH_EN
      FL: begin
        hwy   = (timer_reg < Y_LEN) ? YELLOW : OFF;
        cntry = (timer_reg < Y_LEN) ? RED : OFF;
        if (!flash) state_next = AR2;
      end
`endif
      default: state_next = HG;
    endcase
`ifdef LIGHT_FLASH_EN
    if (flash) state_next = FL;
`endif
  end

endmodule

// File: tb/tb_light_control_timed.sv
// Self-checking bench for light_control_timed: per-cycle phase model plus
// directed scenarios with literal phase durations.
module tb_light_control_timed;

  localparam int TW       = 8;
  localparam int T_HG_MIN = 8;
  localparam int T_CG_MIN = 2;
  localparam int T_CG_MAX = 16;
  localparam int T_Y      = 4;
  localparam int T_AR     = 3;

  logic       clk = 1'b0;
  logic       clear_n;
  logic       car_h;
  logic       car_c;
  logic       flash;
  logic [1:0] hwy;
  logic [1:0] cntry;
  logic [2:0] phase;

  int n_total = 0;
  int n_pass  = 0;

  // Model: current phase number and how many cycles it has been shown so far.
  int m_ph;
  int m_n;

  light_control_timed #(
    .TW(TW), .T_HG_MIN(T_HG_MIN), .T_CG_MIN(T_CG_MIN),
    .T_CG_MAX(T_CG_MAX), .T_Y(T_Y), .T_AR(T_AR)
  ) dut (
    .clk(clk),
    .clear_n(clear_n),
    .car_h(car_h),
    .car_c(car_c),
`ifdef LIGHT_FLASH_EN
    .flash(flash),
`endif
    .hwy(hwy),
    .cntry(cntry),
    .phase(phase)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  function automatic int next_phase(input int ph, input int n, input bit rq, input bit fl);
    if (fl) return 6;
    case (ph)
      0: return (rq && n >= T_HG_MIN) ? 1 : 0;
      1: return (n == T_Y) ? 2 : 1;
      2: return (n == T_AR) ? 3 : 2;
      3: return (n >= T_CG_MIN && (!rq || n == T_CG_MAX)) ? 4 : 3;
      4: return (n == T_Y) ? 5 : 4;
      5: return (n == T_AR) ? 0 : 5;
      6: return 5;
      default: return 0;
    endcase
  endfunction

  function automatic int exp_hwy(input int ph, input int n);
    case (ph)
      0: return 2;
      1: return 1;
      6: return (((n - 1) / T_Y) % 2 == 0) ? 1 : 3;
      default: return 0;
    endcase
  endfunction

  function automatic int exp_cntry(input int ph, input int n);
    case (ph)
      3: return 2;
      4: return 1;
      6: return (((n - 1) / T_Y) % 2 == 0) ? 0 : 3;
      default: return 0;
    endcase
  endfunction

  function automatic bit flash_now();
`ifdef LIGHT_FLASH_EN
    return flash;
`else
    return 1'b0;
`endif
  endfunction

  always @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      m_ph <= 0;
      m_n  <= 1;
    end else begin
      if (next_phase(m_ph, m_n, car_c & ~car_h, flash_now()) == m_ph) m_n <= m_n + 1;
      else m_n <= 1;
      m_ph <= next_phase(m_ph, m_n, car_c & ~car_h, flash_now());
    end
  end

  always @(negedge clk) begin
    chk("model_hwy", int'(hwy), exp_hwy(m_ph, m_n));
    chk("model_cntry", int'(cntry), exp_cntry(m_ph, m_n));
    chk("model_phase", int'(phase), m_ph);
    chk("no_conflict", int'((hwy == 2'd1 || hwy == 2'd2) && (cntry == 2'd1 || cntry == 2'd2)), 0);
  end

  task automatic do_reset(input logic c, input logic h);
    clear_n = 1'b0;
    car_c   = c;
    car_h   = h;
    @(posedge clk);
    #1 clear_n = 1'b1;
    @(negedge clk);
  endtask

  // Called at a negedge showing phase ph; counts how long it lasts.
  task automatic run_len(input int ph, input int exp_len, input string nm);
    int n = 0;
    while (int'(phase) == ph && n < 300) begin
      n++;
      @(negedge clk);
    end
    chk(nm, n, exp_len);
  endtask

  initial begin
    clear_n = 1'b0;
    car_c   = 1'b0;
    car_h   = 1'b0;
    flash   = 1'b0;

    // Idle
    do_reset(1'b0, 1'b0);
    for (int i = 0; i < 100; i++) begin
      chk("idle_phase", int'(phase), 0);
      chk("idle_hwy", int'(hwy), 2);
      chk("idle_cntry", int'(cntry), 0);
      @(negedge clk);
    end

    // Continuous country demand, two full rounds of the cycle
    do_reset(1'b1, 1'b0);
    for (int r = 0; r < 2; r++) begin
      run_len(0, 8, "cont_hg");
      run_len(1, 4, "cont_hy");
      run_len(2, 3, "cont_ar1");
      run_len(3, 16, "cont_cg_max");
      run_len(4, 4, "cont_cy");
      run_len(5, 3, "cont_ar2");
    end
    chk("cont_back_hg", int'(phase), 0);

    // Short one-cycle request after HG minimum has expired
    do_reset(1'b0, 1'b0);
    repeat (20) @(posedge clk);
    #1 car_c = 1'b1;
    @(posedge clk);
    #1 car_c = 1'b0;
    @(negedge clk);
    run_len(1, 4, "short_hy");
    run_len(2, 3, "short_ar1");
    run_len(3, 2, "short_cg_min");
    chk("short_cy", int'(phase), 4);

    // Highway priority
    do_reset(1'b1, 1'b1);
    for (int i = 0; i < 50; i++) begin
      chk("prio_hold_hg", int'(phase), 0);
      @(negedge clk);
    end
    @(posedge clk);
    #1 car_h = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("prio_release_hy", int'(phase), 1);

    // Async reset mid-HY at timer=2
    @(negedge clk);
    @(negedge clk);
    chk("async_pre_hy", int'(phase), 1);
    #2 clear_n = 1'b0;
    #1;
    chk("async_phase", int'(phase), 0);
    chk("async_hwy", int'(hwy), 2);
    chk("async_cntry", int'(cntry), 0);
    @(posedge clk);
    #1 clear_n = 1'b1;
    @(negedge clk);
    run_len(0, 8, "async_hg_min");

`ifdef LIGHT_FLASH_EN
    // Flash entered from CG, then released through AR2
    do_reset(1'b1, 1'b0);
    for (int i = 0; i < 100 && int'(phase) != 3; i++) @(negedge clk);
    chk("flash_in_cg", int'(phase), 3);
    @(posedge clk);
    #1 flash = 1'b1;
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      chk("flash_phase", int'(phase), 6);
      chk("flash_hwy", int'(hwy), ((i / 4) % 2 == 0) ? 1 : 3);
      chk("flash_cntry", int'(cntry), ((i / 4) % 2 == 0) ? 0 : 3);
      @(negedge clk);
    end
    @(posedge clk);
    #1 flash = 1'b0;
    @(negedge clk);
    @(negedge clk);
    run_len(5, 3, "flash_ar2");
    chk("flash_back_hg", int'(phase), 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
